sub_64_seq: RTL and testbench
=============================

SUB_64_SEQ -- requirements
Module: sub_64_seq

Interface
REQ-001 Parameter SLICE_W, default 16: width of the slice processed per cycle. Legal values are 8, 16 and 32. NSLICE = 64/SLICE_W.
REQ-002 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-low reset. Low immediately forces reset state; released synchronously to clock.
REQ-004 Port start, input, 1: operation request, sampled on rising edge.
REQ-005 Port op1, input, 64: minuend, unsigned.
REQ-006 Port op2, input, 64: subtrahend, unsigned.
REQ-007 Port diff, output, 64, registered: result op1 - op2 mod 2^64.
REQ-008 Port brout, output, 1, registered: final borrow-out; 1 iff op1 < op2 unsigned.
REQ-009 Port busy, output, 1, registered: high while an operation is in progress.
REQ-010 Port done, output, 1, registered: one-cycle completion pulse.

Function
REQ-011 FSM states: IDLE, RUN, DONE.
REQ-012 Start acceptance: start=1 sampled in IDLE or DONE accepts a request.
- op1 and op2 are captured into internal operand registers.
- Internal borrow register is cleared to 0.
- Slice index is set to 0.
- FSM goes to RUN; busy=1 from the next cycle.
REQ-013 start=1 sampled in RUN is ignored. It does not re-capture operands and does not affect the result.
REQ-014 Per-cycle slice operation in RUN, with k = slice index:
- partial[k] = op1_r[k] - op2_r[k] - borrow.
- Slice k of the internal accumulator is written.
- borrow is updated to the slice borrow-out.
- k increments.
REQ-015 Slices are processed least-significant first. Borrow ripples across slice boundaries through the borrow register only.
REQ-016 RUN to DONE transition: on the edge processing slice NSLICE-1.
- diff is loaded with the full accumulator, including slice NSLICE-1.
- brout is loaded with the final borrow.
- busy goes to 0.
- done goes to 1.
REQ-017 done is high for exactly one cycle, in DONE. From DONE:
- Next state is IDLE if start=0.
- Next state is RUN if start=1 (back-to-back operation).
REQ-018 Latency: with start sampled at edge E, done=1 and diff/brout are valid in the cycle after edge E+NSLICE. At default SLICE_W this is 4 cycles after the accept edge.
REQ-019 Throughput: at most one result per NSLICE+1 cycles.
REQ-020 diff and brout change only on a completion edge. They hold their value otherwise, including through IDLE and the next RUN.
REQ-021 Changes on op1/op2 after the accept edge have no effect on the in-flight operation.
REQ-022 Arithmetic is purely unsigned. There is no overflow flag; brout is the only out-of-range indicator.
REQ-023 Operands op1 = op2 give diff = 0 and brout = 0.

Reset
REQ-024 When reset=0, the block asynchronously sets:
- state = IDLE;
- diff = 0, brout = 0, busy = 0, done = 0;
- operand registers, accumulator, borrow and slice index = 0.
REQ-025 Reset asserted during RUN aborts the operation. No done pulse is produced for it, and diff/brout read 0.
REQ-026 The first edge after reset release with start=1 accepts normally.

Verification
REQ-027 Basic: op1=0x10, op2=0x3, start for 1 cycle -> diff=0x000000000000000D, brout=0, done pulse 4 cycles after accept, busy high for the 4 RUN cycles.
REQ-028 Full borrow ripple: op1=0, op2=1 -> diff=0xFFFFFFFFFFFFFFFF, brout=1.
REQ-029 Cross-slice borrow: op1=0x0000000100000000, op2=0x1 -> diff=0x00000000FFFFFFFF, brout=0.
REQ-030 Ignore while busy: accept op1=5, op2=2; pulse start with op1=1, op2=9 during RUN -> single done, diff=3, brout=0.
REQ-031 Reset mid-op: assert reset low at the second RUN cycle -> diff=0, brout=0, busy=0, no done. After release, op1=7, op2=7 -> diff=0, brout=0.
REQ-032 Back-to-back: start held high; op1=2, op2=3 then op1=9, op2=4 presented at the DONE cycle -> first done shows diff=0xFFFFFFFFFFFFFFFF, brout=1; second done 5 cycles later shows diff=5, brout=0.

Source files
------------

// File: rtl/sub_64_seq.sv
// Sequential 64-bit unsigned subtractor: one SLICE_W-bit slice per cycle,
// least-significant slice first, with the borrow carried between slices in a register.
module sub_64_seq #(
  parameter int SLICE_W = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] op1,
  input  logic [63:0] op2,
  output logic [63:0] diff,
  output logic        brout,
  output logic        busy,
  output logic        done
);

  localparam int NSLICE = 64 / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_next;
  logic [63:0]        op1_r, op2_r, acc, acc_next;
  logic               borrow;
  logic [IDX_W-1:0]   idx;
  logic [SLICE_W-1:0] a_sl, b_sl;
  logic [SLICE_W:0]   sub;
  logic               accept, finish, busy_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (idx == LAST_IDX) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    accept    = start && (state == IDLE || state == DONE);
    finish    = (state == RUN) && (idx == LAST_IDX);
    busy_next = (state_next == RUN);
  end

  // The top bit of the widened slice difference is the slice borrow-out.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int s = 0; s < NSLICE; s++) begin
      if (idx == IDX_W'(s)) begin
        a_sl = op1_r[s*SLICE_W +: SLICE_W];
        b_sl = op2_r[s*SLICE_W +: SLICE_W];
      end
    end
    sub      = {1'b0, a_sl} - {1'b0, b_sl} - {{SLICE_W{1'b0}}, borrow};
    acc_next = acc;
    for (int s = 0; s < NSLICE; s++) begin
      if (idx == IDX_W'(s)) acc_next[s*SLICE_W +: SLICE_W] = sub[SLICE_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op1_r  <= '0;
      op2_r  <= '0;
      acc    <= '0;
      borrow <= 1'b0;
      idx    <= '0;
      diff   <= '0;
      brout  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      busy <= busy_next;
      done <= finish;
      if (accept) begin
        op1_r  <= op1;
        op2_r  <= op2;
        borrow <= 1'b0;
        idx    <= '0;
      end else if (state == RUN) begin
        acc    <= acc_next;
        borrow <= sub[SLICE_W];
        idx    <= finish ? '0 : idx + 1'b1;
      end
      if (finish) begin
        diff  <= acc_next;
        brout <= sub[SLICE_W];
      end
    end
  end

endmodule

// File: tb/tb_sub_64_seq.sv
// Self-checking bench for sub_64_seq: issued operations push expected results
// into a scoreboard; a monitor pops and compares on every done pulse.
module tb_sub_64_seq;

  localparam int SLICE_W = 16;
  localparam int NSLICE  = 64 / SLICE_W;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] op1, op2;
  logic [63:0] diff;
  logic        brout, busy, done;

  typedef struct {
    logic [63:0] diff;
    logic        brout;
    int          due;
  } expect_t;

  expect_t sb[$];
  int      checks = 0;
  int      passed = 0;
  int      cyc = 0;

  sub_64_seq #(.SLICE_W(SLICE_W)) dut (
    .clock(clock), .reset(reset), .start(start), .op1(op1), .op2(op2),
    .diff(diff), .brout(brout), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: actual=0x%h required=0x%h", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset && done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 64'd1, 64'd0);
      end else begin
        expect_t e;
        e = sb.pop_front();
        checkOutput("diff", diff, e.diff);
        checkOutput("brout", {63'd0, brout}, {63'd0, e.brout});
        checkOutput("latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  // Drives one request starting at a negedge; returns at the negedge after acceptance.
  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b);
    expect_t e;
    start = 1'b1;
    op1   = a;
    op2   = b;
    @(posedge clock);
    #1;
    e.diff  = a - b;
    e.brout = (a < b);
    e.due   = cyc + NSLICE;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
    op1   = {$urandom, $urandom};
    op2   = {$urandom, $urandom};
  endtask

  task automatic waitDone();
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clock);
      seen = done;
    end
    if (!seen) checkOutput("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    logic [63:0] a, b;
    reset = 1'b0;
    start = 1'b0;
    op1   = '0;
    op2   = '0;
    #1;
    checkOutput("reset_diff", diff, 64'd0);
    checkOutput("reset_flags", {61'd0, brout, busy, done}, 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Basic case with busy tracking across the run cycles.
    applyStimulus(64'h10, 64'h3);
    for (int i = 0; i < NSLICE; i++) begin
      checkOutput("busy_run", {63'd0, busy}, 64'd1);
      @(negedge clock);
    end
    checkOutput("busy_done", {63'd0, busy}, 64'd0);

    applyStimulus(64'h0, 64'h1);
    waitDone();
    applyStimulus(64'h0000000100000000, 64'h1);
    waitDone();

    // Start while running is ignored.
    applyStimulus(64'd5, 64'd2);
    start = 1'b1;
    op1   = 64'd1;
    op2   = 64'd9;
    @(negedge clock);
    start = 1'b0;
    waitDone();
    repeat (8) @(negedge clock);

    // Reset in the second run cycle aborts the operation.
    applyStimulus(64'd1000, 64'd1);
    @(negedge clock);
    reset = 1'b0;
    sb.delete();
    #1;
    checkOutput("abort_diff", diff, 64'd0);
    checkOutput("abort_flags", {61'd0, brout, busy, done}, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(64'd7, 64'd7);
    waitDone();
    repeat (2) @(negedge clock);

    // Back-to-back with start held high; second operands arrive in the done cycle.
    applyStimulus(64'd2, 64'd3);
    start = 1'b1;
    waitDone();
    applyStimulus(64'd9, 64'd4);
    waitDone();

    for (int n = 0; n < 25; n++) begin
      case ($urandom_range(0, 3))
        0: begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; end
        1: begin a = {$urandom, $urandom}; b = a; end
        2: begin a = 64'($urandom_range(0, 15)); b = 64'($urandom_range(0, 15)); end
        default: begin a = 64'd0; b = {$urandom, $urandom}; end
      endcase
      applyStimulus(a, b);
      waitDone();
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clock);
    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
